// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall/bubble, flush and hold.
// Define ID_EX_BUBBLE_CNT_EN to add the bubble_cnt counter port.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [12:0]     id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_b5,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_out,
  output logic            ex_valid,
  output logic [12:0]     ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  output logic            ex_funct7_b5
);
  logic rs1_used, rs2_used, load_use, bubble;
  assign rs1_used = (id_ctrl[6:5] == 2'b00) | id_ctrl[0];
  assign rs2_used = ((id_ctrl[4:3] == 2'b00) & (id_ctrl[10] | id_ctrl[1])) | id_ctrl[11];
  assign load_use = id_valid & ex_valid & ex_ctrl[12] & (ex_rd != 5'd0) &
                    ((rs1_used & (ex_rd == id_rs1)) | (rs2_used & (ex_rd == id_rs2)));
  assign stall_out = (load_use | hold) & ~flush;
  // flush beats hold; a load-use bubble only goes in when not held
  assign bubble = flush | (~hold & load_use);
  always_ff @(posedge clk)
    if (rst || bubble) begin
      {ex_valid, ex_ctrl, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm} <= '0;
      {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_b5} <= '0;
    end else if (!hold) begin
      ex_valid     <= id_valid;
      ex_ctrl      <= id_valid ? id_ctrl : 13'd0;
      ex_pc        <= id_pc;
      ex_rs1_val   <= id_rs1_val;
      ex_rs2_val   <= id_rs2_val;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7_b5 <= id_funct7_b5;
    end
`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk)
    if (rst) bubble_cnt <= '0;
    else if (bubble) bubble_cnt <= bubble_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, corner sequences and random stimulus vs. an EX-slot model.
module tb_id_ex_stage;
  localparam int CW = 4;
  localparam logic [12:0] ADD = 13'h0500, LOAD = 13'h1608, LUI = 13'h0448;

  typedef struct packed {
    logic v; logic [12:0] ctrl; logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0] rs1, rs2, rd; logic [2:0] f3; logic f7;
  } id_t;
  typedef struct {
    logic r, f, h; id_t s; logic st, ev; logic [4:0] erd; logic [31:0] epc; int cnt;
  } vec_t;

  logic clk = 0, rst, id_valid, id_funct7_b5, flush, hold, stall_out, ex_valid, ex_funct7_b5;
  logic [12:0] id_ctrl, ex_ctrl;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
  logic [2:0] id_funct3, ex_funct3;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CW-1:0] bubble_cnt;
`endif

  id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .flush(flush), .hold(hold), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .ex_funct7_b5(ex_funct7_b5)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  id_t m;
  int mcnt;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  function automatic id_t mk_id(input logic v, input logic [12:0] c, input logic [31:0] pc,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_t s;
    s.v = v; s.ctrl = c; s.pc = pc; s.rs1v = pc * 3; s.rs2v = ~pc; s.imm = pc + 4;
    s.rs1 = r1; s.rs2 = r2; s.rd = rd; s.f3 = pc[4:2]; s.f7 = pc[3];
    return s;
  endfunction

  // The EX slot holds a pending load whose result the ID instruction actually reads.
  function automatic logic exp_stall(input id_t s, input logic f, input logic h);
    logic reads_a, reads_b, hazard;
    reads_a = s.ctrl[6:5] == 2'b00 || s.ctrl[0];
    reads_b = (s.ctrl[4:3] == 2'b00 && (s.ctrl[10] || s.ctrl[1])) || s.ctrl[11];
    hazard = s.v && m.v && m.ctrl[12] && m.rd != 0 &&
             ((reads_a && m.rd == s.rs1) || (reads_b && m.rd == s.rs2));
    return (hazard || h) && !f;
  endfunction

  task automatic check_ex();
    chk("ex_valid", ex_valid, m.v);
    chk("ex_ctrl", ex_ctrl, m.ctrl);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rs1_val", ex_rs1_val, m.rs1v);
    chk("ex_rs2_val", ex_rs2_val, m.rs2v);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_idx", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
    chk("ex_funct", {ex_funct3, ex_funct7_b5}, {m.f3, m.f7});
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, mcnt);
`endif
  endtask

  task automatic drive(input id_t s, input logic r, input logic f, input logic h);
    rst = r; flush = f; hold = h;
    id_valid = s.v; id_ctrl = s.ctrl; id_pc = s.pc; id_rs1_val = s.rs1v; id_rs2_val = s.rs2v;
    id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_funct3 = s.f3;
    id_funct7_b5 = s.f7;
  endtask

  task automatic run_cycle(input id_t s, input logic r, input logic f, input logic h,
                           output logic st);
    logic es;
    drive(s, r, f, h);
    #1;
    es = exp_stall(s, f, h);
    st = stall_out;
    chk("stall_out", st, es);
    @(posedge clk);
    if (r) begin m = '0; mcnt = 0; end
    else if (f || (!h && es)) begin m = '0; mcnt = (mcnt + 1) % (1 << CW); end
    else if (!h) begin m = s; if (!s.v) m.ctrl = '0; end
    #1;
    check_ex();
  endtask

  vec_t tbl[$];
  function automatic vec_t mk(input logic r, f, h, v, input logic [12:0] c, input logic [31:0] pc,
                              input logic [4:0] r1, r2, rd, input logic st, ev,
                              input logic [4:0] erd, input logic [31:0] epc, input int cnt);
    vec_t x;
    x.r = r; x.f = f; x.h = h; x.s = mk_id(v, c, pc, r1, r2, rd);
    x.st = st; x.ev = ev; x.erd = erd; x.epc = epc; x.cnt = cnt;
    return x;
  endfunction

  initial begin
    logic st;
    int nst, start_cnt;
    id_t s;
    //                 r f h v ctrl  pc      rs1 rs2 rd  st ev erd epc     cnt
    tbl.push_back(mk(0,0,0,1, ADD, 32'h100, 1, 2, 5,  0, 1, 5, 32'h100, 0));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h104, 3, 0, 7,  0, 1, 7, 32'h104, 0));
    tbl.push_back(mk(0,0,0,1, ADD, 32'h108, 1, 7, 8,  1, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0,0,0,1, ADD, 32'h108, 1, 7, 8,  0, 1, 8, 32'h108, 1));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h10c, 3, 0, 0,  0, 1, 0, 32'h10c, 1));
    tbl.push_back(mk(0,0,0,1, ADD, 32'h110, 0, 0, 9,  0, 1, 9, 32'h110, 1));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h114, 9, 0, 7,  0, 1, 7, 32'h114, 1));
    tbl.push_back(mk(0,0,0,1, LUI, 32'h118, 7, 7, 10, 0, 1, 10,32'h118, 1));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h11c, 10,0, 7,  0, 1, 7, 32'h11c, 1));
    tbl.push_back(mk(0,0,1,1, ADD, 32'h120, 7, 0, 11, 1, 1, 7, 32'h11c, 1));
    tbl.push_back(mk(0,0,1,1, ADD, 32'h124, 1, 0, 12, 1, 1, 7, 32'h11c, 1));
    tbl.push_back(mk(0,0,1,1, LUI, 32'h128, 0, 0, 13, 1, 1, 7, 32'h11c, 1));
    tbl.push_back(mk(0,0,0,1, ADD, 32'h12c, 1, 2, 14, 0, 1, 14,32'h12c, 1));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h130, 1, 0, 7,  0, 1, 7, 32'h130, 1));
    tbl.push_back(mk(0,1,0,1, ADD, 32'h134, 7, 0, 15, 0, 0, 0, 32'h0,   2));
    tbl.push_back(mk(0,0,0,0, ADD, 32'h138, 1, 2, 3,  0, 0, 3, 32'h138, 2));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h13c, 1, 0, 6,  0, 1, 6, 32'h13c, 2));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h140, 6, 0, 6,  1, 0, 0, 32'h0,   3));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h140, 6, 0, 6,  0, 1, 6, 32'h140, 3));
    tbl.push_back(mk(0,0,0,1, ADD, 32'h144, 6, 0, 1,  1, 0, 0, 32'h0,   4));
    tbl.push_back(mk(0,0,0,1, ADD, 32'h144, 6, 0, 1,  0, 1, 1, 32'h144, 4));
    tbl.push_back(mk(0,0,0,1, LOAD,32'h148, 0, 0, 7,  0, 1, 7, 32'h148, 4));
    tbl.push_back(mk(1,0,0,1, ADD, 32'h14c, 1, 7, 2,  1, 0, 0, 32'h0,   0));
    tbl.push_back(mk(0,0,0,1, ADD, 32'h14c, 1, 7, 2,  0, 1, 2, 32'h14c, 0));

    // reset with an all-ones control word present in ID
    s = mk_id(1, 13'h1FFF, 32'h40, 7, 7, 7);
    drive(s, 1, 0, 0);
    @(posedge clk);
    m = '0; mcnt = 0;
    #1;
    check_ex();
    run_cycle(s, 1, 0, 0, st);

    foreach (tbl[i]) begin
      run_cycle(tbl[i].s, tbl[i].r, tbl[i].f, tbl[i].h, st);
      chk($sformatf("vec%0d_stall", i), st, tbl[i].st);
      chk($sformatf("vec%0d_valid", i), ex_valid, tbl[i].ev);
      chk($sformatf("vec%0d_rd", i), ex_rd, tbl[i].erd);
      chk($sformatf("vec%0d_pc", i), ex_pc, tbl[i].epc);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk($sformatf("vec%0d_cnt", i), bubble_cnt, tbl[i].cnt);
`endif
    end

    // sixteen load-use bubbles wrap a 4-bit counter back to its start
    nst = 0;
    start_cnt = mcnt;
    for (int k = 0; k < 16; k++) begin
      run_cycle(mk_id(1, LOAD, 32'h200 + k * 8, 0, 0, 7), 0, 0, 0, st);
      run_cycle(mk_id(1, ADD, 32'h204 + k * 8, 1, 7, 3), 0, 0, 0, st);
      nst += int'(st);
    end
    chk("wrap_stalls", nst, 16);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("cnt_wrap", bubble_cnt, start_cnt);
`endif

    for (int k = 0; k < 400; k++) begin
      s.v = $urandom_range(0, 7) != 0;
      s.ctrl = 13'($urandom);
      s.pc = $urandom; s.rs1v = $urandom; s.rs2v = $urandom; s.imm = $urandom;
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.rd = 5'($urandom_range(0, 3)); s.f3 = 3'($urandom); s.f7 = 1'($urandom);
      run_cycle(s, $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
